// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and defaults for the two-master Wishbone arbiter
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;
    localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/wb_arb_timer.sv
// wb_arb_timer: 8-bit grant watchdog, only built when WB_ARB_TIMEOUT_EN is defined
module wb_arb_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);
    logic [7:0] cnt;
    always_ff @(posedge clk)
        if (rst || clear) cnt <= '0;
        else if (enable && cnt != 8'hff) cnt <= cnt + 8'd1;
    assign expired = enable && cnt >= limit;
endmodule

// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter sharing one slave, alternating priority on contention
// Define WB_ARB_TIMEOUT_EN to add a watchdog that terminates stalled grants with ack+err.
module wb_arb2 import wb_arb_pkg::*; #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            wb_ck,
    input  logic            wb_rst,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_w,
    input  logic [DW/8-1:0] m0_sel,
    input  logic            m0_we,
    input  logic            m0_cyc,
    output logic [DW-1:0]   m0_dat_r,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_w,
    input  logic [DW/8-1:0] m1_sel,
    input  logic            m1_we,
    input  logic            m1_cyc,
    output logic [DW-1:0]   m1_dat_r,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic [DW/8-1:0] s_sel,
    output logic            s_we,
    output logic            s_cyc,
    input  logic [DW-1:0]   s_dat_r,
    input  logic            s_ack
);
    arb_state_t state, state_nx;
    logic last, last_nx, g0, g1, to;
    assign g0 = state == GNT0;
    assign g1 = state == GNT1;
    assign s_cyc = (g0 && m0_cyc) || (g1 && m1_cyc);
    assign s_adr = g0 ? m0_adr : g1 ? m1_adr : '0;
    assign s_dat_w = g0 ? m0_dat_w : g1 ? m1_dat_w : '0;
    assign s_sel = g0 ? m0_sel : g1 ? m1_sel : '0;
    assign s_we = g0 ? m0_we : g1 ? m1_we : 1'b0;
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign m0_ack = g0 && s_cyc && (s_ack || to);
    assign m1_ack = g1 && s_cyc && (s_ack || to);
    assign m0_err = g0 && to;
    assign m1_err = g1 && to;
`ifdef WB_ARB_TIMEOUT_EN
    logic expired;
    wb_arb_timer u_timer (
        .clk(wb_ck),
        .rst(wb_rst),
        .clear(state == IDLE),
        .enable(state != IDLE),
        .limit(8'(TIMEOUT)),
        .expired(expired)
    );
    // a real slave ack in the same cycle takes precedence over the timeout
    assign to = expired && s_cyc && !s_ack;
`else
    logic [7:0] unused_limit;
    assign unused_limit = 8'(TIMEOUT);
    assign to = 1'b0;
`endif
    always_ff @(posedge wb_ck)
        if (wb_rst) begin
            state <= IDLE;
            last <= 1'b1;
        end else begin
            state <= state_nx;
            last <= last_nx;
        end
    // every grant returns through IDLE, which gives the other master its turn
    always_comb begin
        state_nx = state;
        last_nx = last;
        if (state == IDLE)
            state_nx = m0_cyc && m1_cyc ? (last ? GNT0 : GNT1) : m0_cyc ? GNT0 : m1_cyc ? GNT1 : IDLE;
        else if (!s_cyc || s_ack || to) begin
            state_nx = IDLE;
            last_nx = g1;
        end
    end
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: directed vector table, stall/watchdog sequence and randomized traffic vs. a transaction model
module tb_wb_arb2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TOEN = 1'b1;
`else
    localparam bit TOEN = 1'b0;
`endif
    logic wb_ck = 1'b0;
    logic wb_rst = 1'b1;
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dat_w [2];
    logic [DW/8-1:0] sel [2];
    logic we [2];
    logic cyc [2];
    logic [DW-1:0] dat_r [2];
    logic ack [2];
    logic err [2];
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w, s_dat_r;
    logic [DW/8-1:0] s_sel;
    logic s_we, s_cyc, s_ack;
    int total = 0;
    int bad = 0;

    always #5 wb_ck = ~wb_ck;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_ck(wb_ck), .wb_rst(wb_rst),
        .m0_adr(adr[0]), .m0_dat_w(dat_w[0]), .m0_sel(sel[0]), .m0_we(we[0]), .m0_cyc(cyc[0]),
        .m0_dat_r(dat_r[0]), .m0_ack(ack[0]), .m0_err(err[0]),
        .m1_adr(adr[1]), .m1_dat_w(dat_w[1]), .m1_sel(sel[1]), .m1_we(we[1]), .m1_cyc(cyc[1]),
        .m1_dat_r(dat_r[1]), .m1_ack(ack[1]), .m1_err(err[1]),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc),
        .s_dat_r(s_dat_r), .s_ack(s_ack)
    );

    typedef struct {
        logic rst, c0, c1, sa;
        logic sc, a0, a1;
        logic [AW-1:0] sadr;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t v(input logic rst, c0, c1, sa, sc, a0, a1, input logic [AW-1:0] sadr);
        vec_t r;
        r.rst = rst; r.c0 = c0; r.c1 = c1; r.sa = sa;
        r.sc = sc; r.a0 = a0; r.a1 = a1; r.sadr = sadr;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_ck);
        #1;
    endtask

    // transaction-level reference: owner of the slave (-1 none) and who was served last
    int own, last, wd;
    logic ea [2], ee [2], pa [2];
    logic sc, to;

    initial begin
        for (int n = 0; n < 2; n++) begin
            adr[n] = '0; dat_w[n] = '0; sel[n] = '0; we[n] = 1'b0; cyc[n] = 1'b0;
        end
        s_dat_r = '0;
        s_ack = 1'b0;
        repeat (2) step();
        wb_rst = 1'b0;

        // rst c0 c1 sa | s_cyc ack0 ack1 s_adr
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h100));
        tbl.push_back(v(0, 1, 0, 1, 1, 1, 0, 32'h100));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 1, 1, 0, 1, 32'h200));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1, 0, 32'h100));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 1, 0, 0, 32'h200));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h200));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h100));
        tbl.push_back(v(0, 1, 0, 1, 1, 1, 0, 32'h100));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, 32'h100));
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 1, 0, 0, 32'h100));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h100));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0));

        adr[0] = 32'h100;
        adr[1] = 32'h200;
        foreach (tbl[i]) begin
            wb_rst = tbl[i].rst;
            cyc[0] = tbl[i].c0;
            cyc[1] = tbl[i].c1;
            s_ack = tbl[i].sa;
            @(negedge wb_ck);
            check($sformatf("vec%0d s_cyc", i), s_cyc, tbl[i].sc);
            check($sformatf("vec%0d m0_ack", i), ack[0], tbl[i].a0);
            check($sformatf("vec%0d m1_ack", i), ack[1], tbl[i].a1);
            check($sformatf("vec%0d s_adr", i), s_adr, tbl[i].sadr);
            check($sformatf("vec%0d err", i), {err[0], err[1]}, 2'b00);
            check($sformatf("vec%0d dat_r", i), {dat_r[0], dat_r[1]}, 64'h0);
            step();
        end
        wb_rst = 1'b0;

        // silent slave: watchdog expiry when enabled, otherwise an indefinitely held grant
        cyc[0] = 1'b1;
        s_ack = 1'b0;
        @(negedge wb_ck);
        check("stall idle s_cyc", s_cyc, 1'b0);
        step();
        for (int i = 0; i <= (TOEN ? TO + 1 : 299); i++) begin
            if (TOEN && i == TO + 1) cyc[0] = 1'b0;
            @(negedge wb_ck);
            check($sformatf("stall%0d s_cyc", i), s_cyc, TOEN ? (i <= TO) : 1'b1);
            check($sformatf("stall%0d m0_ack", i), ack[0], TOEN && i == TO);
            check($sformatf("stall%0d m0_err", i), err[0], TOEN && i == TO);
            check($sformatf("stall%0d m1_ack", i), ack[1], 1'b0);
            step();
        end
        cyc[0] = 1'b0;
        repeat (2) step();

        // randomized traffic against the model
        own = -1; last = 1; wd = 0;
        pa[0] = 1'b0; pa[1] = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            wb_rst = (t == 0) || ($urandom_range(0, 199) == 0);
            s_ack = (t % 600 < 400) ? ($urandom_range(0, 2) == 0) : 1'b0;
            s_dat_r = $urandom;
            for (int n = 0; n < 2; n++) begin
                if ((cyc[n] && (pa[n] || $urandom_range(0, 29) == 0)) || (!cyc[n] && $urandom_range(0, 3) == 0)) begin
                    cyc[n] = cyc[n] ? 1'($urandom) : 1'b1;
                    adr[n] = $urandom;
                    dat_w[n] = $urandom;
                    sel[n] = 4'($urandom);
                    we[n] = 1'($urandom);
                end
            end
            sc = (own == 0 && cyc[0]) || (own == 1 && cyc[1]);
            to = TOEN && sc && wd >= TO && !s_ack;
            for (int n = 0; n < 2; n++) begin
                ea[n] = own == n && sc && (s_ack || to);
                ee[n] = own == n && to;
            end
            @(negedge wb_ck);
            check("rnd s_cyc", s_cyc, sc);
            check("rnd s_adr", s_adr, own == 0 ? adr[0] : own == 1 ? adr[1] : '0);
            check("rnd s_dat_w", s_dat_w, own == 0 ? dat_w[0] : own == 1 ? dat_w[1] : '0);
            check("rnd s_sel", s_sel, own == 0 ? sel[0] : own == 1 ? sel[1] : '0);
            check("rnd s_we", s_we, own == 0 ? we[0] : own == 1 ? we[1] : 1'b0);
            check("rnd acks", {ack[0], ack[1]}, {ea[0], ea[1]});
            check("rnd errs", {err[0], err[1]}, {ee[0], ee[1]});
            check("rnd dat_r", {dat_r[0], dat_r[1]}, {s_dat_r, s_dat_r});
            if (wb_rst) begin
                own = -1; last = 1; wd = 0;
            end else if (own < 0) begin
                if (cyc[0] && cyc[1]) own = 1 - last;
                else if (cyc[0]) own = 0;
                else if (cyc[1]) own = 1;
                wd = 0;
            end else if (!sc || ea[own]) begin
                last = own;
                own = -1;
            end else wd++;
            pa[0] = ea[0] && !wb_rst;
            pa[1] = ea[1] && !wb_rst;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 Parameter AW, default 32, address width of masters and slave.
REQ-002 Parameter DW, default 32, data width; byte selects are DW/8 bits.
REQ-003 Parameter TIMEOUT, default 15, slave-ack watchdog limit in cycles (valid 2..255).
REQ-004 One clock; reset is synchronous and active-high: wb_ck input 1, wb_rst input 1.
REQ-005 mN_adr input AW, mN_dat_w input DW, mN_sel input DW/8, mN_we input 1, mN_cyc input 1: master N request, N = 0, 1.
REQ-006 mN_dat_r output DW, mN_ack output 1, mN_err output 1: master N response.
REQ-007 s_adr output AW, s_dat_w output DW, s_sel output DW/8, s_we output 1, s_cyc output 1: shared slave request.
REQ-008 s_dat_r input DW, s_ack input 1: shared slave response.

Function
REQ-009 States IDLE, GNT0, GNT1; s_cyc SHALL be high only in GNTn while mN_cyc is high.
REQ-010 IDLE: m0_cyc only -> GNT0; m1_cyc only -> GNT1; both -> the master not served last; neither -> stay.
REQ-011 Latency: mN_cyc first high at edge k -> s_cyc high from edge k+1.
REQ-012 In GNTn, s_adr/s_dat_w/s_sel/s_we SHALL mirror master n combinationally; in IDLE they SHALL be zero.
REQ-013 s_dat_r SHALL drive both mN_dat_r; s_ack SHALL reach only the granted master, qualified by s_cyc.
REQ-014 GNTn -> IDLE on the edge where s_ack & s_cyc, or where mN_cyc is low (master abort); last-served register <= n.
REQ-015 IDLE is held at least one cycle between grants; back-to-back requests from both masters SHALL alternate.
REQ-016 A request by the non-granted master SHALL be held off, never dropped, while it keeps cyc high.
REQ-017 s_ack arriving in IDLE SHALL be ignored.

Reset
REQ-018 wb_rst SHALL force IDLE, last-served = 1 (so m0 wins first contention) and watchdog = 0, all taking effect at the next edge.
REQ-019 After reset all outputs SHALL be 0; reset mid-transaction SHALL drop s_cyc with no ack to either master.

Configuration
REQ-020 Macro WB_ARB_TIMEOUT_EN defined: an 8-bit watchdog counts cycles in GNTn, clears on entry; on reaching TIMEOUT without s_ack, mN_ack and mN_err SHALL pulse high for one cycle to the granted master, s_cyc SHALL drop, state -> IDLE.
REQ-021 Macro undefined: no counter is built, mN_err SHALL be constant 0, and a grant waits indefinitely for s_ack.
REQ-022 s_ack coinciding with timeout SHALL win: normal ack, mN_err = 0.

Structure
REQ-023 Package wb_arb_pkg SHALL hold the state enumeration and default TIMEOUT constant.
REQ-024 Watchdog SHALL be a separate sub-module wb_arb_timer (clear, enable, limit in; expired out), instantiated only under WB_ARB_TIMEOUT_EN.
REQ-025 Mux and FSM SHALL live in wb_arb2; no other sub-modules.

Verification
REQ-026 m0_cyc at cycle 2, adr 0x100, slave acks 2 cycles later -> s_cyc cycle 3, s_adr 0x100, m0_ack one cycle, m1_ack 0.
REQ-027 Both cyc high at cycle 2, continuously re-requesting -> grants m0, m1, m0, m1, IDLE cycle between each.
REQ-028 m1 granted, m1_cyc dropped before ack -> IDLE next edge, no ack, then pending m0 granted.
REQ-029 WB_ARB_TIMEOUT_EN, TIMEOUT 15, slave silent -> m0_ack and m0_err high exactly 15 cycles after grant, s_cyc low after.
REQ-030 wb_rst pulsed in GNT0 with s_ack pending -> s_cyc 0 next cycle, no mN_ack, next contention grants m0.
REQ-031 Macro undefined, slave silent 300 cycles -> grant held, m0_err 0 throughout.
